// File: rtl/nvme_admin_arb_pkg.sv
// Shared types and width helpers for the NVMe admin mailbox arbiter.
package nvme_admin_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int DEF_IDX_W = 2;
    localparam int DEF_SEQ_W = 14;

    // CID layout for the default 4-requester, 16-bit tag build
    typedef struct packed {
        logic [DEF_SEQ_W-1:0] seq;
        logic [DEF_IDX_W-1:0] idx;
    } cid_t;

    function automatic int f_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int f_cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nvme_admin_arbiter_rr.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
    import nvme_admin_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = f_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the far end so the offset closest to the pointer wins
    always_comb begin : p_scan
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvme_admin_arbiter.sv
// Shares one admin submission mailbox among N_REQ sources, stamping CIDs
// and tracking per-requester outstanding commands for completion routing.
module nvme_admin_arbiter
    import nvme_admin_arb_pkg::*;
#(
    parameter  int WIDTH   = 170,
    parameter  int N_REQ   = 4,
    parameter  int TAG_LSB = 16,
    parameter  int TAG_W   = 16,
    parameter  int MAX_OUT = 4,
    parameter  int TIMEOUT = 1024,
    localparam int IDX_W   = f_idx_w(N_REQ),
    localparam int CNT_W   = f_cnt_w(MAX_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_wrreq,
    input  logic                   fifo_wrfull,
    input  logic                   cpl_valid,
    input  logic [TAG_W-1:0]       cpl_tag,
    output logic [N_REQ-1:0]       cpl_route,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic                   stall_timeout,
    output logic                   err_cpl
);

    localparam int SEQ_W = TAG_W - IDX_W;
    localparam int STL_W = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gidx;
    logic [IDX_W-1:0] w_gidx;
    logic [IDX_W-1:0] w_cidx;
    logic [SEQ_W-1:0] r_seq;
    logic [CNT_W-1:0] r_out [N_REQ];
    logic [STL_W-1:0] r_stall;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_cmd;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_inc;
    logic [N_REQ-1:0] w_dec;
    logic [N_REQ-1:0] r_route;
    logic             w_any;
    logic             w_busy;
    logic             w_write;
    logic             w_cpl_ok;
    logic             r_stall_to;
    logic             r_err;
    logic             w_unused_tag;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid[i] && (r_out[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any)        w_next = ISSUE;
            ISSUE:   if (!fifo_wrfull) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state == ISSUE);
        w_write   = w_busy && !fifo_wrfull;
        req_ready = (r_state == IDLE) ? w_gnt : '0;
    end

    always_comb begin
        w_cmd = req_data[int'(w_gidx)*WIDTH +: WIDTH];
        w_cmd[TAG_LSB +: TAG_W] = {r_seq, w_gidx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_seq      <= '0;
            r_gidx     <= '0;
            r_data     <= '0;
            r_stall    <= '0;
            r_stall_to <= 1'b0;
        end else begin
            r_stall_to <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_data <= w_cmd;
                r_gidx <= w_gidx;
            end
            if (w_write) begin
                r_seq   <= r_seq + 1'b1;
                r_ptr   <= (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
                r_stall <= '0;
            end else if (w_busy) begin
                // Timeout only flags the stall; the command stays pending
                if (r_stall == STL_W'(TIMEOUT - 1)) begin
                    r_stall    <= '0;
                    r_stall_to <= 1'b1;
                end else begin
                    r_stall <= r_stall + 1'b1;
                end
            end
        end
    end

    assign w_cidx       = cpl_tag[IDX_W-1:0];
    assign w_unused_tag = ^cpl_tag[TAG_W-1:IDX_W];
    assign w_cpl_ok     = cpl_valid
                       && ({1'b0, w_cidx} < (IDX_W+1)'(N_REQ))
                       && (r_out[w_cidx] != '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_inc[i] = w_write  && (r_gidx == IDX_W'(i));
            w_dec[i] = w_cpl_ok && (w_cidx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) r_out[i] <= '0;
            r_route <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_inc[i] && !w_dec[i])      r_out[i] <= r_out[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i]) r_out[i] <= r_out[i] - 1'b1;
            end
            r_route <= w_dec;
            if (cpl_valid && !w_cpl_ok) r_err <= 1'b1;
        end
    end

    assign fifo_data     = r_data;
    assign fifo_wrreq    = w_write;
    assign busy          = w_busy;
    assign grant_idx     = r_gidx;
    assign cpl_route     = r_route;
    assign stall_timeout = r_stall_to;
    assign err_cpl       = r_err;

endmodule

// File: tb/tb_nvme_admin_arbiter.sv
// Directed table-driven bench for nvme_admin_arbiter plus a FIFO stall sequence.
module tb_nvme_admin_arbiter;

    localparam int W = 170;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_data;
    logic           fifo_wrreq;
    logic           fifo_wrfull;
    logic           cpl_valid;
    logic [15:0]    cpl_tag;
    logic [N-1:0]   cpl_route;
    logic [1:0]     grant_idx;
    logic           busy;
    logic           stall_timeout;
    logic           err_cpl;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] base [N];

    always #5 clk = ~clk;

    nvme_admin_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_data     (fifo_data),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_wrfull   (fifo_wrfull),
        .cpl_valid     (cpl_valid),
        .cpl_tag       (cpl_tag),
        .cpl_route     (cpl_route),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .stall_timeout (stall_timeout),
        .err_cpl       (err_cpl)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  vld;
        bit          cv;
        logic [15:0] ctag;
        logic [3:0]  e_rdy;
        bit          e_wr;
        logic [1:0]  e_g;
        logic [15:0] e_cid;
        logic [3:0]  e_route;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] vld, bit cv,
                                logic [15:0] ctag, logic [3:0] rdy,
                                bit wr, logic [1:0] g, logic [15:0] cid,
                                logic [3:0] route, bit err);
        vec_t v;
        v.rst = r; v.vld = vld; v.cv = cv; v.ctag = ctag;
        v.e_rdy = rdy; v.e_wr = wr; v.e_g = g; v.e_cid = cid;
        v.e_route = route; v.e_err = err;
        return v;
    endfunction

    function automatic logic [W-1:0] expw(int g, logic [15:0] cid);
        logic [W-1:0] w;
        w = base[g];
        w[31:16] = cid;
        return w;
    endfunction

    task automatic chk(string nm, int row, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        int pulses;
        int pos;
        int wr_seen;

        rst = 1'b1;
        req_valid = '0;
        fifo_wrfull = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            base[i] = {5{34'(64'h2_1357_9BDF + 64'(i) * 64'h1111_1111)}};
            base[i][31:16] = 16'hFFFF;
            req_data[i*W +: W] = base[i];
        end

        // single requester 2, CID field all ones on input
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h4, 0, 16'h0, 4'h4, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 1, 2'd2, 16'h0002, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        // all four requesting: rotation 0,1,2,3,0 with seq 0..4
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h1, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h0, 1, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h0, 1, 2'd1, 16'h0005, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h4, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h0, 1, 2'd2, 16'h000A, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h8, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h0, 1, 2'd3, 16'h000F, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h1, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0, 4'h0, 1, 2'd0, 16'h0010, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        // requester 1 fills to MAX_OUT, then completion re-enables it
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 1, 2'd1, 16'h0001, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 1, 2'd1, 16'h0005, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 1, 2'd1, 16'h0009, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 1, 2'd1, 16'h000D, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 1, 16'h1, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h2, 0));
        // issue and completion for requester 1 in the same cycle
        tbl.push_back(mk(0, 4'h2, 1, 16'h1, 4'h0, 1, 2'd1, 16'h0011, 4'h0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h2, 0, 2'd0, 16'h0000, 4'h2, 0));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0, 4'h0, 1, 2'd1, 16'h0015, 4'h0, 0));
        tbl.push_back(mk(0, 4'h3, 0, 16'h0, 4'h1, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 1, 2'd0, 16'h0018, 4'h0, 0));
        // unexpected completions set sticky error
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h3, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 1));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 1));
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        // reset while a command sits in ISSUE
        tbl.push_back(mk(0, 4'h1, 0, 16'h0, 4'h1, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0, 4'h0, 0, 2'd0, 16'h0000, 4'h0, 0));

        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            rst = v.rst;
            req_valid = v.vld;
            fifo_wrfull = 1'b0;
            cpl_valid = v.cv;
            cpl_tag = v.ctag;
            @(negedge clk);
            chk("req_ready", r, W'(req_ready), W'(v.e_rdy));
            chk("fifo_wrreq", r, W'(fifo_wrreq), W'(v.e_wr));
            chk("busy", r, W'(busy), W'(v.e_wr));
            chk("cpl_route", r, W'(cpl_route), W'(v.e_route));
            chk("err_cpl", r, W'(err_cpl), W'(v.e_err));
            if (v.e_wr) begin
                chk("grant_idx", r, W'(grant_idx), W'(v.e_g));
                chk("fifo_data", r, fifo_data, expw(int'(v.e_g), v.e_cid));
            end
            if (v.rst) begin
                chk("rst_fifo_data", r, fifo_data, '0);
                chk("rst_grant_idx", r, W'(grant_idx), '0);
                chk("rst_stall_timeout", r, W'(stall_timeout), '0);
            end
            @(posedge clk);
            #1;
        end

        // FIFO held full across the stall timeout
        cpl_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'h1;
        @(negedge clk);
        chk("stall_grant", 100, W'(req_ready), W'(4'h1));
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        fifo_wrfull = 1'b1;
        pulses = 0;
        pos = 0;
        wr_seen = 0;
        for (int c = 1; c <= 1030; c++) begin
            @(negedge clk);
            if (stall_timeout) begin
                pulses++;
                pos = c;
            end
            if (fifo_wrreq) wr_seen++;
            @(posedge clk);
            #1;
        end
        chk("stall_pulses", 101, W'(pulses), W'(1));
        chk("stall_pulse_cycle", 102, W'(pos), W'(1025));
        chk("stall_no_write", 103, W'(wr_seen), W'(0));
        chk("stall_busy", 104, W'(busy), W'(1));
        fifo_wrfull = 1'b0;
        @(negedge clk);
        chk("release_wrreq", 105, W'(fifo_wrreq), W'(1));
        chk("release_data", 106, fifo_data, expw(0, 16'h0000));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_idle", 107, W'(busy), W'(0));
        chk("release_no_pulse", 108, W'(stall_timeout), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
